// File: rtl/inv_sqrt_stream_ctrl.sv
// inv_sqrt_stream_ctrl: valid/ready wrapper around the fixed-latency fast_inv_sqrt pipeline with a credit-managed result FIFO.
// Optional ISQ_HWM_EN adds occ_hwm, the peak occupancy (in flight + queued) since reset.
module inv_sqrt_stream_ctrl #(
  parameter int DATA_W = 27,
  parameter int LATENCY = 5,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] isq_data_in,
  input  logic [DATA_W-1:0] isq_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef ISQ_HWM_EN
  ,
  output logic [CW-1:0]     occ_hwm
`endif
);
  logic [LATENCY-1:0] tag, tag_next;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count, count_next, occ;
  logic acc, push, pop;
  function automatic logic [CW-1:0] popc(input logic [LATENCY-1:0] v);
    popc = '0;
    for (int i = 0; i < LATENCY; i++) popc = popc + CW'(v[i]);
  endfunction
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign acc = in_valid & in_ready;
  assign push = tag[LATENCY-1];
  assign out_valid = fifo_count != '0;
  assign pop = out_valid & out_ready;
  // Credit counts every operand not yet popped, so a tagged result always finds a free slot.
  assign occ = popc(tag) + fifo_count;
  assign in_ready = occ < CW'(FIFO_DEPTH);
  assign busy = |tag | out_valid;
  assign out_data = mem[rd_ptr];
  assign tag_next = LATENCY'({tag, acc});
  always_comb count_next = push & ~pop ? fifo_count + CW'(1) : pop & ~push ? fifo_count - CW'(1) : fifo_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      isq_data_in <= '0;
      tag <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      isq_data_in <= acc ? in_data : '0;
      tag <= tag_next;
      fifo_count <= count_next;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
    end
  end
  always_ff @(posedge clk) if (push & ~rst) mem[wr_ptr] <= isq_data_out;
`ifdef ISQ_HWM_EN
  logic [CW-1:0] occ_next;
  assign occ_next = popc(tag_next) + count_next;
  always_ff @(posedge clk) begin
    if (rst) occ_hwm <= '0;
    else if (occ_next > occ_hwm) occ_hwm <= occ_next;
  end
`endif
endmodule

// File: tb/tb_inv_sqrt_stream_ctrl.sv
// tb_inv_sqrt_stream_ctrl: random and directed stimulus against a queue-based model of operands awaiting pop.
module tb_inv_sqrt_stream_ctrl;
  localparam int DW = 27;
  localparam int LAT = 5;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [DW-1:0] in_data = '0, isq_data_in, isq_data_out, out_data;
`ifdef ISQ_HWM_EN
  logic [CW-1:0] occ_hwm;
`endif
  inv_sqrt_stream_ctrl #(.DATA_W(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .isq_data_in(isq_data_in), .isq_data_out(isq_data_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef ISQ_HWM_EN
    , .occ_hwm(occ_hwm)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] isq_f(input logic [DW-1:0] x);
    return {x[0], x[DW-1:1]} ^ 27'h5A5A5A5;
  endfunction
  // Stand-in unit: free-running, no reset, result visible LAT-1 edges after data_in is driven.
  logic [DW-1:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= isq_data_in;
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign isq_data_out = isq_f(pipe[LAT-2]);
  typedef struct {int rdy; logic [DW-1:0] v;} ent_t;
  ent_t q[$];
  int cyc = 0, checks = 0, errors = 0, hwm = 0, n_acc_obs = 0;
  logic [DW-1:0] exp_isq = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    logic ev, acc_e, pop_e;
    int nq;
    @(negedge clk);
    ev = q.size() > 0 && q[0].rdy <= cyc;
    if (!rst) begin
      nq = 0;
      foreach (q[i]) if (q[i].rdy <= cyc) nq++;
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("isq_data_in", 32'(isq_data_in), 32'(exp_isq));
      chk("fifo_count", 32'(dut.fifo_count), 32'(nq));
      if (ev) chk("out_data", 32'(out_data), 32'(q[0].v));
`ifdef ISQ_HWM_EN
      chk("occ_hwm", 32'(occ_hwm), 32'(hwm));
`endif
      if (in_valid && in_ready) n_acc_obs++;
    end
    acc_e = !rst && in_valid && q.size() < DEPTH;
    pop_e = !rst && ev && out_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      exp_isq = '0;
      hwm = 0;
    end else begin
      if (pop_e) void'(q.pop_front());
      if (acc_e) q.push_back('{cyc + LAT, isq_f(in_data)});
      exp_isq = acc_e ? in_data : '0;
      if (q.size() > hwm) hwm = q.size();
    end
    #1;
  endtask
  task automatic run(input int n, input logic iv, input logic orr);
    for (int i = 0; i < n; i++) begin
      in_valid = iv;
      out_ready = orr;
      in_data = DW'($urandom);
      tick();
    end
  endtask
  initial begin
    rst = 1;
    in_valid = 1;
    tick();
    tick();
    rst = 0;
    in_valid = 0;
    run(3, 0, 0);
    in_valid = 1;
    out_ready = 1;
    in_data = 27'h2000000;
    tick();
    in_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    run(64, 1, 1);
    run(12, 0, 1);
    n_acc_obs = 0;
    run(14, 1, 0);
    chk("bp_accepted", 32'(n_acc_obs), 32'd8);
    run(20, 0, 1);
    run(8, 1, 0);
    run(30, 1, 1);
    run(12, 0, 1);
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      in_data = DW'($urandom);
      tick();
    end
    run(15, 0, 1);
    run(5, 1, 0);
    run(2, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    run(10, 0, 1);
    run(40, 1, 1);
    run(15, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
